// File: rtl/kl_arbiter_nby1.sv
// kl_arbiter_nby1: merges N_PORTS KLink uplinks onto one downlink.
// Requests are granted round-robin and held across write bursts; responses
// are steered back by destination ID and held across read bursts.
// Optional feature macro: KL_ARB_DROP_UNROUTED_EN -- when defined, responses
// whose dstid maps to no uplink are sunk (whole burst); otherwise they stall.
module kl_arbiter_nby1 #(
  parameter int         N_PORTS         = 4,
  parameter logic [4:0] SRC_ID_BASE     = 5'd0,
  parameter int         MAX_BURST_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_PORTS*32-1:0] up_req_addr,
  input  logic [N_PORTS-1:0]    up_req_wen,
  input  logic [N_PORTS*64-1:0] up_req_wdata,
  input  logic [N_PORTS*8-1:0]  up_req_wmask,
  input  logic [N_PORTS*3-1:0]  up_req_size,
  input  logic [N_PORTS-1:0]    up_req_valid,
  output logic [N_PORTS-1:0]    up_req_ready,
  output logic [N_PORTS*64-1:0] up_resp_rdata,
  output logic [N_PORTS-1:0]    up_resp_valid,
  input  logic [N_PORTS-1:0]    up_resp_ready,
  output logic [31:0]           dn_req_addr,
  output logic                  dn_req_wen,
  output logic [63:0]           dn_req_wdata,
  output logic [7:0]            dn_req_wmask,
  output logic [2:0]            dn_req_size,
  output logic [4:0]            dn_req_srcid,
  output logic                  dn_req_valid,
  input  logic                  dn_req_ready,
  input  logic [63:0]           dn_resp_rdata,
  input  logic [2:0]            dn_resp_size,
  input  logic [4:0]            dn_resp_dstid,
  input  logic                  dn_resp_valid,
  output logic                  dn_resp_ready
);

  localparam int IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CNT_W  = MAX_BURST_WIDTH;
  localparam int BEAT_W = MAX_BURST_WIDTH + 1;
  localparam logic [4:0] N5 = 5'(N_PORTS);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [1:0] {REQ_IDLE, REQ_HOLD, REQ_BURST} req_state_t;
  typedef enum logic {RSP_IDLE, RSP_BURST} rsp_state_t;

  // Beats in a transfer: bytes/8, never less than one.
  function automatic logic [BEAT_W-1:0] beats_of(input logic [2:0] size);
    if (size <= 3'd3) return BEAT_W'(1);
    return BEAT_W'(1) << (size - 3'd3);
  endfunction

  // Per-port views of the flattened request buses.
  logic [31:0] addr_a  [N_PORTS];
  logic [63:0] wdata_a [N_PORTS];
  logic [7:0]  wmask_a [N_PORTS];
  logic [2:0]  size_a  [N_PORTS];

  for (genvar g = 0; g < N_PORTS; g++) begin : g_unpack
    assign addr_a[g]  = up_req_addr[g*32 +: 32];
    assign wdata_a[g] = up_req_wdata[g*64 +: 64];
    assign wmask_a[g] = up_req_wmask[g*8 +: 8];
    assign size_a[g]  = up_req_size[g*3 +: 3];
  end

  // Request channel state
  req_state_t        req_state, req_state_n;
  idx_t              owner, owner_n;
  idx_t              last_grant, last_grant_n;
  cnt_t              req_cnt, req_cnt_n;
  idx_t              rr_pick, cand, cur_owner;
  logic              rr_found;
  logic              req_hs;
  logic [BEAT_W-1:0] req_beats;

  // Round-robin search starting one past the last granted port.
  always_comb begin
    rr_pick  = last_grant;
    rr_found = 1'b0;
    cand     = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      cand = idx_t'((int'(last_grant) + k) % N_PORTS);
      if (!rr_found && up_req_valid[cand]) begin
        rr_found = 1'b1;
        rr_pick  = cand;
      end
    end
  end

  assign cur_owner    = (req_state == REQ_IDLE) ? rr_pick : owner;
  assign dn_req_addr  = addr_a[cur_owner];
  assign dn_req_wen   = up_req_wen[cur_owner];
  assign dn_req_wdata = wdata_a[cur_owner];
  assign dn_req_wmask = wmask_a[cur_owner];
  assign dn_req_size  = size_a[cur_owner];
  assign dn_req_srcid = SRC_ID_BASE + 5'(cur_owner);
  assign req_beats    = beats_of(size_a[cur_owner]);
  assign req_hs       = dn_req_valid && dn_req_ready;

  // Downlink valid and uplink ready follow the current owner combinationally.
  always_comb begin
    dn_req_valid = 1'b0;
    up_req_ready = '0;
    if (!rst) begin
      if (req_state == REQ_IDLE) begin
        dn_req_valid = rr_found;
        if (rr_found) up_req_ready[cur_owner] = dn_req_ready;
      end else begin
        dn_req_valid = up_req_valid[owner];
        up_req_ready[owner] = dn_req_ready;
      end
    end
  end

  // Request FSM next state: hold an unaccepted winner, lock for write bursts.
  always_comb begin
    req_state_n  = req_state;
    owner_n      = owner;
    last_grant_n = last_grant;
    req_cnt_n    = req_cnt;
    case (req_state)
      REQ_IDLE, REQ_HOLD: begin
        if (req_hs) begin
          last_grant_n = cur_owner;
          owner_n      = cur_owner;
          if (dn_req_wen && (req_beats > BEAT_W'(1))) begin
            req_state_n = REQ_BURST;
            req_cnt_n   = cnt_t'(req_beats - BEAT_W'(1));
          end else begin
            req_state_n = REQ_IDLE;
          end
        end else if ((req_state == REQ_IDLE) && rr_found) begin
          req_state_n = REQ_HOLD;
          owner_n     = rr_pick;
        end
      end
      REQ_BURST: begin
        if (req_hs) begin
          req_cnt_n = req_cnt - cnt_t'(1);
          if (req_cnt == cnt_t'(1)) req_state_n = REQ_IDLE;
        end
      end
      default: req_state_n = REQ_IDLE;
    endcase
  end

  // Request FSM registers; last_grant resets so that port 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_state  <= REQ_IDLE;
      owner      <= '0;
      last_grant <= idx_t'(N_PORTS - 1);
      req_cnt    <= '0;
    end else begin
      req_state  <= req_state_n;
      owner      <= owner_n;
      last_grant <= last_grant_n;
      req_cnt    <= req_cnt_n;
    end
  end

  // Response channel state
  rsp_state_t        rsp_state, rsp_state_n;
  idx_t              rsp_port, rsp_port_n;
  cnt_t              rsp_cnt, rsp_cnt_n;
  logic [5:0]        dst_diff;
  logic              dst_ok;
  logic              route_ok;
  idx_t              rsp_route;
  logic              rsp_hs;
  logic [BEAT_W-1:0] rsp_beats;
`ifdef KL_ARB_DROP_UNROUTED_EN
  logic              rsp_drop, rsp_drop_n;
`endif

  assign dst_diff  = {1'b0, dn_resp_dstid} - {1'b0, SRC_ID_BASE};
  assign dst_ok    = !dst_diff[5] && (dst_diff[4:0] < N5);
  assign rsp_route = (rsp_state == RSP_BURST) ? rsp_port : idx_t'(dst_diff[4:0]);
`ifdef KL_ARB_DROP_UNROUTED_EN
  assign route_ok  = (rsp_state == RSP_BURST) ? !rsp_drop : dst_ok;
`else
  assign route_ok  = (rsp_state == RSP_BURST) ? 1'b1 : dst_ok;
`endif
  assign rsp_beats     = beats_of(dn_resp_size);
  assign rsp_hs        = dn_resp_valid && dn_resp_ready;
  assign up_resp_rdata = {N_PORTS{dn_resp_rdata}};

  // Steer the response valid/ready pair to the routed port.
  always_comb begin
    up_resp_valid = '0;
    dn_resp_ready = 1'b0;
    if (!rst && dn_resp_valid) begin
      if (route_ok) begin
        up_resp_valid[rsp_route] = 1'b1;
        dn_resp_ready            = up_resp_ready[rsp_route];
      end
`ifdef KL_ARB_DROP_UNROUTED_EN
      else begin
        dn_resp_ready = 1'b1;
      end
`endif
    end
  end

  // Response FSM next state: lock the route for the length of a read burst.
  always_comb begin
    rsp_state_n = rsp_state;
    rsp_port_n  = rsp_port;
    rsp_cnt_n   = rsp_cnt;
`ifdef KL_ARB_DROP_UNROUTED_EN
    rsp_drop_n  = rsp_drop;
`endif
    case (rsp_state)
      RSP_IDLE: begin
        if (rsp_hs && (rsp_beats > BEAT_W'(1))) begin
          rsp_state_n = RSP_BURST;
          rsp_port_n  = rsp_route;
          rsp_cnt_n   = cnt_t'(rsp_beats - BEAT_W'(1));
`ifdef KL_ARB_DROP_UNROUTED_EN
          rsp_drop_n  = !dst_ok;
`endif
        end
      end
      RSP_BURST: begin
        if (rsp_hs) begin
          rsp_cnt_n = rsp_cnt - cnt_t'(1);
          if (rsp_cnt == cnt_t'(1)) rsp_state_n = RSP_IDLE;
        end
      end
      default: rsp_state_n = RSP_IDLE;
    endcase
  end

  // Response FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_state <= RSP_IDLE;
      rsp_port  <= '0;
      rsp_cnt   <= '0;
`ifdef KL_ARB_DROP_UNROUTED_EN
      rsp_drop  <= 1'b0;
`endif
    end else begin
      rsp_state <= rsp_state_n;
      rsp_port  <= rsp_port_n;
      rsp_cnt   <= rsp_cnt_n;
`ifdef KL_ARB_DROP_UNROUTED_EN
      rsp_drop  <= rsp_drop_n;
`endif
    end
  end

endmodule

// File: tb/tb_kl_arbiter_nby1.sv
// Bench for kl_arbiter_nby1 (N=4, SRC_ID_BASE=0): directed scenarios followed
// by random traffic, all checked against a transaction-level model.
module tb_kl_arbiter_nby1;
  localparam int N    = 4;
  localparam int BASE = 0;
`ifdef KL_ARB_DROP_UNROUTED_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N*32-1:0] up_req_addr;
  logic [N-1:0]    up_req_wen;
  logic [N*64-1:0] up_req_wdata;
  logic [N*8-1:0]  up_req_wmask;
  logic [N*3-1:0]  up_req_size;
  logic [N-1:0]    up_req_valid;
  logic [N-1:0]    up_req_ready;
  logic [N*64-1:0] up_resp_rdata;
  logic [N-1:0]    up_resp_valid;
  logic [N-1:0]    up_resp_ready;
  logic [31:0]     dn_req_addr;
  logic            dn_req_wen;
  logic [63:0]     dn_req_wdata;
  logic [7:0]      dn_req_wmask;
  logic [2:0]      dn_req_size;
  logic [4:0]      dn_req_srcid;
  logic            dn_req_valid;
  logic            dn_req_ready;
  logic [63:0]     dn_resp_rdata;
  logic [2:0]      dn_resp_size;
  logic [4:0]      dn_resp_dstid;
  logic            dn_resp_valid;
  logic            dn_resp_ready;

  kl_arbiter_nby1 #(.N_PORTS(N), .SRC_ID_BASE(5'(BASE)), .MAX_BURST_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .up_req_addr(up_req_addr), .up_req_wen(up_req_wen), .up_req_wdata(up_req_wdata),
    .up_req_wmask(up_req_wmask), .up_req_size(up_req_size), .up_req_valid(up_req_valid),
    .up_req_ready(up_req_ready), .up_resp_rdata(up_resp_rdata), .up_resp_valid(up_resp_valid),
    .up_resp_ready(up_resp_ready), .dn_req_addr(dn_req_addr), .dn_req_wen(dn_req_wen),
    .dn_req_wdata(dn_req_wdata), .dn_req_wmask(dn_req_wmask), .dn_req_size(dn_req_size),
    .dn_req_srcid(dn_req_srcid), .dn_req_valid(dn_req_valid), .dn_req_ready(dn_req_ready),
    .dn_resp_rdata(dn_resp_rdata), .dn_resp_size(dn_resp_size), .dn_resp_dstid(dn_resp_dstid),
    .dn_resp_valid(dn_resp_valid), .dn_resp_ready(dn_resp_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Uplink masters: each holds one transaction until all its beats are taken.
  bit          m_valid [N];
  bit          m_wen   [N];
  int          m_size  [N];
  int          m_left  [N];
  logic [31:0] m_addr  [N];
  logic [63:0] m_wdata [N];
  logic [7:0]  m_wmask [N];

  // Downlink response source.
  bit rd_valid;
  int rd_dst, rd_alt, rd_size, rd_left, rd_total;

  // Reference model: who owns each channel and how many beats remain.
  int ar_owner, ar_rem, ar_last;
  int rs_lock, rs_rem;
  bit rand_mode;

  // Outputs captured at the last check point.
  logic [4:0]   obs_srcid;
  logic [N-1:0] obs_req_rdy;
  logic [N-1:0] obs_resp_vld;
  logic         obs_drr;

  function automatic int beats(input int size);
    int b;
    b = (1 << size) / 8;
    if (b < 1) b = 1;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input int p, input bit wen, input int size);
    m_valid[p] = 1'b1;
    m_wen[p]   = wen;
    m_size[p]  = size;
    m_left[p]  = wen ? beats(size) : 1;
    m_addr[p]  = $urandom;
  endtask

  task automatic start_rsp(input int dst, input int size, input int alt);
    rd_valid = 1'b1;
    rd_dst   = dst;
    rd_size  = size;
    rd_total = beats(size);
    rd_left  = rd_total;
    rd_alt   = alt;
  endtask

  task automatic drive();
    if (rand_mode) begin
      for (int i = 0; i < N; i++)
        if (!m_valid[i] && $urandom_range(0, 2) == 0)
          start_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 7));
      dn_req_ready  = ($urandom_range(0, 3) != 0);
      up_resp_ready = N'($urandom);
      if (!rd_valid && $urandom_range(0, 2) == 0)
        start_rsp(DROP ? $urandom_range(0, 11) : $urandom_range(0, N - 1),
                  $urandom_range(0, 7), 0);
      rd_alt = $urandom_range(0, 31);
    end
    for (int i = 0; i < N; i++) begin
      m_wdata[i] = {$urandom, $urandom};
      m_wmask[i] = 8'($urandom);
      up_req_valid[i]        = m_valid[i];
      up_req_wen[i]          = m_wen[i];
      up_req_size[i*3 +: 3]  = 3'(m_size[i]);
      up_req_addr[i*32 +: 32] = m_addr[i];
      up_req_wdata[i*64 +: 64] = m_wdata[i];
      up_req_wmask[i*8 +: 8] = m_wmask[i];
    end
    dn_resp_valid = rd_valid;
    dn_resp_dstid = 5'((rd_left == rd_total) ? rd_dst : rd_alt);
    dn_resp_size  = 3'(rd_size);
    dn_resp_rdata = {$urandom, $urandom};
  endtask

  task automatic check_and_update();
    int g;
    int p;
    bit ev;
    bit ok;
    bit exp_drr;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    obs_srcid    = dn_req_srcid;
    obs_req_rdy  = up_req_ready;
    obs_resp_vld = up_resp_valid;
    obs_drr      = dn_resp_ready;

    // Request side: held owner, else first valid port after the last grant.
    g = -1;
    if (ar_owner >= 0) g = ar_owner;
    else
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (ar_last + k) % N;
        if (g < 0 && m_valid[c]) g = c;
      end
    ev = (g >= 0) && m_valid[g];
    chk("dn_req_valid", dn_req_valid, ev);
    exp_rdy = '0;
    if (ev) begin
      chk("dn_req_srcid", dn_req_srcid, BASE + g);
      chk("dn_req_addr", dn_req_addr, m_addr[g]);
      chk("dn_req_wen", dn_req_wen, m_wen[g]);
      chk("dn_req_size", dn_req_size, m_size[g]);
      chk("dn_req_wdata", dn_req_wdata, m_wdata[g]);
      chk("dn_req_wmask", dn_req_wmask, m_wmask[g]);
      if (dn_req_ready) exp_rdy[g] = 1'b1;
    end
    chk("up_req_ready", up_req_ready, exp_rdy);
    if (ev && dn_req_ready) begin
      if (ar_rem == 0) begin
        ar_last  = g;
        ar_rem   = m_wen[g] ? beats(m_size[g]) - 1 : 0;
        ar_owner = (ar_rem > 0) ? g : -1;
      end else begin
        ar_rem--;
        if (ar_rem == 0) ar_owner = -1;
      end
      m_left[g]--;
      if (m_left[g] == 0) m_valid[g] = 1'b0;
    end else if (ev && ar_owner < 0) begin
      ar_owner = g;
    end

    // Response side: locked port during a burst, else dstid - base.
    exp_rv = '0;
    if (rd_valid) begin
      p  = (rs_lock >= 0) ? rs_lock : int'(dn_resp_dstid) - BASE;
      ok = (p >= 0) && (p < N);
      exp_drr = DROP;
      if (ok) begin
        exp_rv[p] = 1'b1;
        exp_drr   = up_resp_ready[p];
        chk("up_resp_rdata", up_resp_rdata[p*64 +: 64], dn_resp_rdata);
      end
      chk("dn_resp_ready", dn_resp_ready, exp_drr);
      if (exp_drr) begin
        if (rs_rem == 0) begin
          if (beats(rd_size) > 1) begin
            rs_rem  = beats(rd_size) - 1;
            rs_lock = p;
          end
        end else begin
          rs_rem--;
          if (rs_rem == 0) rs_lock = -1;
        end
        rd_left--;
        if (rd_left == 0) rd_valid = 1'b0;
      end
    end
    chk("up_resp_valid", up_resp_valid, exp_rv);
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    check_and_update();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycles(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      drive();
      @(negedge clk);
      chk("rst_up_req_ready", up_req_ready, '0);
      chk("rst_dn_req_valid", dn_req_valid, '0);
      chk("rst_up_resp_valid", up_resp_valid, '0);
      chk("rst_dn_resp_ready", dn_resp_ready, '0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    rd_valid = 1'b0;
    ar_owner = -1; ar_rem = 0; ar_last = N - 1;
    rs_lock  = -1; rs_rem = 0;
  endtask

  initial begin
    int n1;
    int drseq [5];
    rst = 1'b1;
    rand_mode = 1'b0;
    rd_valid = 1'b0; rd_dst = 0; rd_alt = 0; rd_size = 0; rd_left = 0; rd_total = 0;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0; m_wen[i] = 1'b0; m_size[i] = 0; m_left[i] = 0;
      m_addr[i] = '0; m_wdata[i] = '0; m_wmask[i] = '0;
    end
    dn_req_ready  = 1'b1;
    up_resp_ready = '1;

    // Reset with every channel being offered traffic.
    for (int i = 0; i < N; i++) start_req(i, 1'b0, 0);
    start_rsp(1, 0, 0);
    reset_cycles(3);

    // All ports stream single-beat reads: grants rotate 0,1,2,3,0.
    dn_req_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) if (!m_valid[i]) start_req(i, 1'b0, 3);
      tick();
      chk("rr_srcid", obs_srcid, c % 4);
    end
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;

    // Port 1 4-beat write while port 2 waits; ready toggles 1,0,1,1,1.
    drseq = '{1, 0, 1, 1, 1};
    start_req(1, 1'b1, 5);
    start_req(2, 1'b0, 2);
    n1 = 0;
    for (int c = 0; c < 5; c++) begin
      dn_req_ready = 1'(drseq[c]);
      tick();
      chk("burst_srcid", obs_srcid, 1);
      chk("burst_port2_ready", obs_req_rdy[2], 1'b0);
      if (obs_req_rdy[1] && dn_req_ready) n1++;
    end
    chk("burst_port1_beats", n1, 4);
    dn_req_ready = 1'b1;
    tick();
    chk("after_burst_srcid", obs_srcid, 2);
    chk("after_burst_ready", obs_req_rdy, 4'b0100);

    // Port 3 stalled for 5 cycles, port 0 arrives meanwhile: owner stays 3.
    dn_req_ready = 1'b0;
    start_req(3, 1'b0, 0);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) start_req(0, 1'b0, 0);
      tick();
      chk("hold_srcid", obs_srcid, 3);
    end
    dn_req_ready = 1'b1;
    tick();
    chk("hold_accept", obs_req_rdy, 4'b1000);
    tick();
    chk("hold_next_srcid", obs_srcid, 0);
    chk("hold_next_ready", obs_req_rdy, 4'b0001);

    // 8-beat response to port 2; dstid switches to 0 after the first beat.
    up_resp_ready = '1;
    start_rsp(2, 6, 0);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("rsp_burst_route", obs_resp_vld, 4'b0100);
    end
    start_rsp(0, 0, 0);
    tick();
    chk("rsp_after_burst", obs_resp_vld, 4'b0001);

    // Unroutable dstid 9: sunk in one cycle, or stalls the channel.
    start_rsp(9, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("unrouted_vld", obs_resp_vld, '0);
      chk("unrouted_ready", obs_drr, DROP && (c == 0));
    end
    rd_valid = 1'b0;

    // Reset lands on beat 2 of a 4-beat write; port 0 must win afterwards.
    start_req(1, 1'b1, 5);
    start_req(0, 1'b0, 0);
    for (int i = 0; i < N; i++) m_valid[i] = (i == 1);
    tick();
    chk("pre_rst_srcid", obs_srcid, 1);
    start_req(0, 1'b0, 0);
    reset_cycles(1);
    start_req(0, 1'b0, 0);
    start_req(1, 1'b0, 0);
    tick();
    chk("post_rst_srcid", obs_srcid, 0);
    chk("post_rst_ready", obs_req_rdy, 4'b0001);
    tick();
    chk("post_rst_next", obs_srcid, 1);

    // Random traffic on both channels at once.
    rand_mode = 1'b1;
    for (int c = 0; c < 3000; c++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
